tlb_array: RTL
==============

TLB_ARRAY -- requirements
Module: tlb_array

Interface
REQ-001 Parameter TLBNUM, default 16, entry count; power of two, 4..64.
REQ-002 Parameter FILL_LFSR, default 0; 0 = round-robin fill pointer, 1 = 8-bit LFSR fill pointer.
REQ-003 Derived IDXW = clog2(TLBNUM); entry format = 89-bit TLB item {E, ASID[9:0], G, PS[5:0], VPPN[18:0], PI0[25:0], PI1[25:0]}, each PI = {V, D, MAT[1:0], PLV[1:0], PPN[19:0]}.
REQ-004 Ports, clock and reset first; one clock, reset synchronous active-high:
- aclk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous active-high reset.
- s_valid  in  1  lookup request.
- s_vpn  in  20  VA[31:12].
- s_asid  in  10  lookup ASID.
- s_rvalid  out  1  lookup result valid, one cycle after s_valid.
- s_found  out  1  hit.
- s_index  out  IDXW  hit index.
- s_ps  out  6  hit page size.
- s_pi  out  26  selected PI of hit entry.
- w_en  in  1  write entry at w_index (tlbwr).
- w_fill  in  1  write entry at internal fill pointer (tlbfill).
- w_index  in  IDXW  write index.
- w_entry  in  89  entry to write.
- w_ready  out  1  write/inv accepted this cycle.
- r_index  in  IDXW  read index (tlbrd).
- r_entry  out  89  registered entry at r_index of previous cycle.
- inv_valid  in  1  invtlb request.
- inv_op  in  3  invtlb op.
- inv_asid  in  10  invtlb ASID.
- inv_vpn  in  20  invtlb VA[31:12].
- inv_busy  out  1  invalidation walk in progress.
- inv_done  out  1  one-cycle pulse at walk end.
- inv_err  out  1  one-cycle pulse, op 7 rejected.

Function
REQ-005 Match(entry, vpn, asid) = E and (G or ASID==asid) and (PS==21 ? VPPN[18:9]==vpn[19:10] : VPPN==vpn[19:1]); only PS 12 and 21 are legal.
REQ-006 Odd-page select = vpn[0] for PS 12, vpn[9] for PS 21; selects PI1 when 1, else PI0.
REQ-007 Lookup: 1-cycle latency, results registered; s_rvalid = s_valid delayed one cycle; multiple hits resolve to lowest index.
REQ-008 On miss with s_rvalid=1: s_found=0, s_index=0, s_ps=0, s_pi=0.
REQ-009 Lookup sees array state before any same-cycle write or invalidation.
REQ-010 w_ready = not inv_busy; w_en/w_fill/inv_valid while w_ready=0 are ignored.
REQ-011 w_en has priority over w_fill in the same cycle; w_fill then ignored and fill pointer unchanged.
REQ-012 w_fill writes at fill pointer and advances it: round-robin wraps TLBNUM-1 to 0; LFSR (taps 8,6,5,4, seed 8'h01) index = low IDXW bits.
REQ-013 r_entry registers array[r_index] each cycle, showing pre-write contents on same-cycle write to r_index.
REQ-014 Invalidation FSM states IDLE, WALK; IDLE->WALK on inv_valid with inv_op 0..6 and w_ready; walk index 0..TLBNUM-1, one entry per cycle; WALK->IDLE after index TLBNUM-1 with inv_done=1 that cycle.
REQ-015 inv_busy=1 in WALK; walk takes exactly TLBNUM cycles.
REQ-016 Per entry, clear E when: op0/op1 all; op2 G=1; op3 G=0; op4 G=0 and ASID==inv_asid; op5 G=0, ASID match, VA match; op6 (G=1 or ASID match) and VA match; VA match per REQ-005 using latched inv_vpn.
REQ-017 inv_op, inv_asid, inv_vpn latched at acceptance; input changes during WALK have no effect.
REQ-018 inv_op=7 in IDLE: inv_err pulses one cycle, no state change, FSM stays IDLE.
REQ-019 Same-cycle w_en and inv_valid in IDLE: write committed first, walk starts next cycle and sees written entry.

Reset
REQ-020 On reset all entries cleared to 0, fill pointer 0 (LFSR 8'h01), FSM IDLE.
REQ-021 All outputs 0 during and one cycle after reset, except w_ready=1.
REQ-022 Reset during WALK aborts immediately; no inv_done pulse.

Verification
REQ-023 Write idx3 {E=1,ASID=5,G=0,PS=12,VPPN=0x12345}, lookup vpn=0x2468B asid=5 -> next cycle s_found=1, s_index=3, s_pi=PI1.
REQ-024 Same entry, lookup asid=6 -> s_found=0, s_pi=0; set G=1 -> hit.
REQ-025 PS=21 entries at idx2 and idx7 both matching -> s_index=2; vpn[9]=0 selects PI0.
REQ-026 TLBNUM+1 w_fill writes, round-robin -> indices 0..15 then 0; r_index sweep confirms.
REQ-027 invtlb op5 asid=5 matching idx3 -> inv_busy 16 cycles, w_en ignored, inv_done at cycle 16, idx3 E=0, others unchanged.
REQ-028 inv_op=7 -> inv_err one cycle, inv_busy=0; reset at walk cycle 5 -> all E=0, no inv_done.

Source files
------------

// File: rtl/tlb_array_if.sv
// Lookup, write/read and invalidate signal bundle for tlb_array.
// slave = the TLB array, master = the requesting pipeline.
interface tlb_array_if #(
  parameter int TLBNUM = 16
);
  localparam int IDXW = $clog2(TLBNUM);

  logic            s_valid;
  logic [19:0]     s_vpn;
  logic [9:0]      s_asid;
  logic            s_rvalid;
  logic            s_found;
  logic [IDXW-1:0] s_index;
  logic [5:0]      s_ps;
  logic [25:0]     s_pi;

  logic            w_en;
  logic            w_fill;
  logic [IDXW-1:0] w_index;
  logic [88:0]     w_entry;
  logic            w_ready;

  logic [IDXW-1:0] r_index;
  logic [88:0]     r_entry;

  logic            inv_valid;
  logic [2:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [19:0]     inv_vpn;
  logic            inv_busy;
  logic            inv_done;
  logic            inv_err;

  modport master (
    output s_valid, s_vpn, s_asid, w_en, w_fill, w_index, w_entry, r_index,
           inv_valid, inv_op, inv_asid, inv_vpn,
    input  s_rvalid, s_found, s_index, s_ps, s_pi, w_ready, r_entry,
           inv_busy, inv_done, inv_err
  );

  modport slave (
    input  s_valid, s_vpn, s_asid, w_en, w_fill, w_index, w_entry, r_index,
           inv_valid, inv_op, inv_asid, inv_vpn,
    output s_rvalid, s_found, s_index, s_ps, s_pi, w_ready, r_entry,
           inv_busy, inv_done, inv_err
  );
endinterface

// File: rtl/tlb_array.sv
// Fully associative TLB array: 1-cycle registered lookup, tlbwr/tlbfill writes,
// registered tlbrd port and a one-entry-per-cycle invtlb walk.
//
// state | meaning
// IDLE  | lookups, writes and invtlb requests accepted
// WALK  | invalidation walk, one entry per cycle; writes ignored
module tlb_array #(
  parameter int TLBNUM    = 16,
  parameter int FILL_LFSR = 0
) (
  input logic        aclk,
  input logic        reset,
  tlb_array_if.slave tlb
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);
  localparam logic [IDXW-1:0] PRE_LAST_IDX = IDXW'(TLBNUM - 2);

  // entry fields: E 88 | ASID 87:78 | G 77 | PS 76:71 | VPPN 70:52 | PI0 51:26 | PI1 25:0
  typedef enum logic {IDLE, WALK} state_e;

  function automatic logic va_match(input logic [88:0] ent, input logic [18:0] vpn_hi);
    if (ent[76:71] == 6'd21) return ent[70:61] == vpn_hi[18:9];
    return ent[70:52] == vpn_hi;
  endfunction

  function automatic logic asid_eq(input logic [88:0] ent, input logic [9:0] asid);
    return ent[87:78] == asid;
  endfunction

  logic [88:0]     entries_q [TLBNUM];
  state_e          state_q;
  logic [IDXW-1:0] walk_idx_q;
  logic [2:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [18:0]     inv_vpn_q;
  logic            inv_busy_q, inv_done_q, inv_err_q;

  logic            s_rvalid_q, s_found_q;
  logic [IDXW-1:0] s_index_q;
  logic [5:0]      s_ps_q;
  logic [25:0]     s_pi_q;
  logic [88:0]     r_entry_q;

  logic            s_found_d;
  logic [IDXW-1:0] s_index_d;
  logic [5:0]      s_ps_d;
  logic [25:0]     s_pi_d;
  logic [88:0]     hit_ent;
  logic            odd_sel;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    s_found_d = 1'b0;
    s_index_d = '0;
    hit_ent   = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (entries_q[i][88] && (entries_q[i][77] || asid_eq(entries_q[i], tlb.s_asid)) &&
          va_match(entries_q[i], tlb.s_vpn[19:1])) begin
        s_found_d = 1'b1;
        s_index_d = IDXW'(i);
        hit_ent   = entries_q[i];
      end
    end
    odd_sel = (hit_ent[76:71] == 6'd21) ? tlb.s_vpn[9] : tlb.s_vpn[0];
    s_ps_d  = hit_ent[76:71];
    s_pi_d  = odd_sel ? hit_ent[25:0] : hit_ent[51:26];
  end

  logic [88:0] walk_ent;
  logic        walk_g, walk_asid, walk_va, inv_clear;

  assign walk_ent  = entries_q[walk_idx_q];
  assign walk_g    = walk_ent[77];
  assign walk_asid = asid_eq(walk_ent, inv_asid_q);
  assign walk_va   = va_match(walk_ent, inv_vpn_q);

  always_comb begin
    inv_clear = 1'b0;
    case (inv_op_q)
      3'd0, 3'd1: inv_clear = 1'b1;
      3'd2:       inv_clear = walk_g;
      3'd3:       inv_clear = ~walk_g;
      3'd4:       inv_clear = ~walk_g & walk_asid;
      3'd5:       inv_clear = ~walk_g & walk_asid & walk_va;
      3'd6:       inv_clear = (walk_g | walk_asid) & walk_va;
      default:    inv_clear = 1'b0;
    endcase
  end

  logic            fill_fire;
  logic [IDXW-1:0] fill_idx;

  assign fill_fire = (state_q == IDLE) & ~tlb.w_en & tlb.w_fill;

  if (FILL_LFSR != 0) begin : g_lfsr
    logic [7:0] lfsr_q;
    always_ff @(posedge aclk) begin
      if (reset) lfsr_q <= 8'h01;
      else if (fill_fire) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    assign fill_idx = lfsr_q[IDXW-1:0];
  end else begin : g_rr
    logic [IDXW-1:0] rr_q;
    always_ff @(posedge aclk) begin
      if (reset) rr_q <= '0;
      else if (fill_fire) rr_q <= rr_q + 1'b1;
    end
    assign fill_idx = rr_q;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) entries_q[i] <= '0;
      state_q    <= IDLE;
      walk_idx_q <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vpn_q  <= '0;
      inv_busy_q <= 1'b0;
      inv_done_q <= 1'b0;
      inv_err_q  <= 1'b0;
      s_rvalid_q <= 1'b0;
      s_found_q  <= 1'b0;
      s_index_q  <= '0;
      s_ps_q     <= '0;
      s_pi_q     <= '0;
      r_entry_q  <= '0;
    end else begin
      s_rvalid_q <= tlb.s_valid;
      s_found_q  <= tlb.s_valid & s_found_d;
      s_index_q  <= (tlb.s_valid & s_found_d) ? s_index_d : '0;
      s_ps_q     <= (tlb.s_valid & s_found_d) ? s_ps_d : '0;
      s_pi_q     <= (tlb.s_valid & s_found_d) ? s_pi_d : '0;
      r_entry_q  <= entries_q[tlb.r_index];
      inv_done_q <= 1'b0;
      inv_err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (tlb.w_en) entries_q[tlb.w_index] <= tlb.w_entry;
          else if (tlb.w_fill) entries_q[fill_idx] <= tlb.w_entry;
          if (tlb.inv_valid) begin
            if (tlb.inv_op == 3'd7) begin
              inv_err_q <= 1'b1;
            end else begin
              state_q    <= WALK;
              inv_busy_q <= 1'b1;
              walk_idx_q <= '0;
              inv_op_q   <= tlb.inv_op;
              inv_asid_q <= tlb.inv_asid;
              inv_vpn_q  <= tlb.inv_vpn[19:1];
            end
          end
        end
        WALK: begin
          if (inv_clear) entries_q[walk_idx_q][88] <= 1'b0;
          if (walk_idx_q == LAST_IDX) begin
            state_q    <= IDLE;
            inv_busy_q <= 1'b0;
          end else begin
            walk_idx_q <= walk_idx_q + 1'b1;
            // done is registered, so raise it as the walk steps onto the last entry
            if (walk_idx_q == PRE_LAST_IDX) inv_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tlb.s_rvalid = s_rvalid_q;
  assign tlb.s_found  = s_found_q;
  assign tlb.s_index  = s_index_q;
  assign tlb.s_ps     = s_ps_q;
  assign tlb.s_pi     = s_pi_q;
  assign tlb.w_ready  = ~inv_busy_q;
  assign tlb.r_entry  = r_entry_q;
  assign tlb.inv_busy = inv_busy_q;
  assign tlb.inv_done = inv_done_q;
  assign tlb.inv_err  = inv_err_q;
endmodule
